// File: rtl/mul_pkg.sv
// Elaboration helpers that size the 4:2 compressor tree from the operand width.
package mul_pkg;

  // Rows after one level: each group of four becomes two; a leftover three goes through a csa.
  function automatic int next_rows(int r);
    return 2 * (r / 4) + (((r % 4) == 3) ? 2 : (r % 4));
  endfunction

  function automatic int rows_at_level(int n, int k);
    int r;
    r = n;
    for (int i = 0; i < k; i++) r = next_rows(r);
    return r;
  endfunction

  function automatic int num_4to2_levels(int n);
    int r;
    int l;
    r = n;
    l = 0;
    while (r > 2) begin
      r = next_rows(r);
      l++;
    end
    return l;
  endfunction

endpackage

// File: rtl/mul_cells.sv
// Row-wide carry-save cells: 3:2 counter and 4:2 compressor. Carries come out pre-shifted
// one column left and the carry out of the top column is dropped (results are mod 2^W).
module csa #(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  output logic [W-1:0] sum,
  output logic [W-1:0] carry
);
  logic [W-1:0] maj;

  assign sum   = a ^ b ^ c;
  assign maj   = (a & b) | (a & c) | (b & c);
  assign carry = maj << 1;
endmodule

module c_4to2 #(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  input  logic [W-1:0] d,
  output logic [W-1:0] sum,
  output logic [W-1:0] carry
);
  logic [W-1:0] x, cout, cin, cy;

  assign x    = a ^ b ^ c;
  assign cout = (a & b) | (a & c) | (b & c);
  // Lateral carry comes from the neighbouring column's first adder, so it never ripples.
  assign cin  = cout << 1;
  assign sum  = x ^ d ^ cin;
  assign cy   = (x & d) | (x & cin) | (d & cin);
  assign carry = cy << 1;
endmodule

// File: rtl/mul_pp_gen.sv
// Combinational partial-product generator; signed mode uses Baugh-Wooley rows.
module mul_pp_gen #(
  parameter int DATA_LEN = 8
) (
  input  logic [DATA_LEN-1:0]   op1,
  input  logic [DATA_LEN-1:0]   op2,
  input  logic                  is_signed,
  output logic [2*DATA_LEN-1:0] pp [DATA_LEN]
);
  always_comb begin
    for (int i = 0; i < DATA_LEN; i++) begin
      pp[i] = '0;
      for (int j = 0; j < DATA_LEN; j++) begin
        // Cross terms that pair exactly one sign bit carry negative weight, so they are inverted.
        pp[i][i+j] = (op1[j] & op2[i]) ^ (is_signed & ((i == DATA_LEN-1) != (j == DATA_LEN-1)));
      end
    end
    // Correction constants land in columns that row 0 and the top row leave empty.
    pp[0][DATA_LEN]            = is_signed;
    pp[DATA_LEN-1][2*DATA_LEN-1] = is_signed;
  end
endmodule

// File: rtl/mul_4to2_tree_pipe.sv
// Three-stage DATA_LEN x DATA_LEN multiplier: pp + first 4:2 level, remaining tree, final add.
module mul_4to2_tree_pipe
  import mul_pkg::*;
#(
  parameter int DATA_LEN = 8,
  parameter int TAG_W    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_LEN-1:0]   op1,
  input  logic [DATA_LEN-1:0]   op2,
  input  logic                  is_signed,
  input  logic [TAG_W-1:0]      in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [2*DATA_LEN-1:0] mul_result,
  output logic [TAG_W-1:0]      out_tag
);
  localparam int W    = 2 * DATA_LEN;
  localparam int NLEV = num_4to2_levels(DATA_LEN);
  localparam int R1   = rows_at_level(DATA_LEN, 1);

  typedef logic [W-1:0] row_t;
  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
  } side_t;

  // Handshake: a stage loads when it is empty or its successor takes its beat this cycle.
  row_t  pp [DATA_LEN];
  row_t  lvl_in  [NLEV][DATA_LEN];
  row_t  lvl_out [NLEV][DATA_LEN];
  row_t  s1_rows_d [R1];
  row_t  s1_rows_q [R1];
  row_t  red_sum, red_carry;
  row_t  s2_sum_d, s2_sum_q, s2_carry_d, s2_carry_q, res_d, res_q;
  side_t s1_d, s1_q, s2_d, s2_q, s3_d, s3_q;
  logic  rdy1, rdy2, rdy3;

  mul_pp_gen #(.DATA_LEN(DATA_LEN)) u_pp_gen (
    .op1       (op1),
    .op2       (op2),
    .is_signed (is_signed),
    .pp        (pp)
  );

  // Level 0 feeds the S1 register; levels 1.. reduce the registered rows down to two.
  for (genvar k = 0; k < NLEV; k++) begin : g_lvl
    localparam int RIN  = rows_at_level(DATA_LEN, k);
    localparam int ROUT = rows_at_level(DATA_LEN, k + 1);
    localparam int NQ   = RIN / 4;
    for (genvar r = 0; r < DATA_LEN; r++) begin : g_in
      if (r >= RIN) begin : g_tie
        assign lvl_in[k][r] = '0;
      end else if (k == 0) begin : g_pp
        assign lvl_in[k][r] = pp[r];
      end else if (k == 1) begin : g_reg
        assign lvl_in[k][r] = s1_rows_q[r];
      end else begin : g_chain
        assign lvl_in[k][r] = lvl_out[k-1][r];
      end
    end
    for (genvar q = 0; q < NQ; q++) begin : g_c42
      c_4to2 #(.W(W)) u_c42 (
        .a(lvl_in[k][4*q]), .b(lvl_in[k][4*q+1]), .c(lvl_in[k][4*q+2]), .d(lvl_in[k][4*q+3]),
        .sum(lvl_out[k][2*q]), .carry(lvl_out[k][2*q+1])
      );
    end
    if ((RIN % 4) == 3) begin : g_csa
      csa #(.W(W)) u_csa (
        .a(lvl_in[k][4*NQ]), .b(lvl_in[k][4*NQ+1]), .c(lvl_in[k][4*NQ+2]),
        .sum(lvl_out[k][2*NQ]), .carry(lvl_out[k][2*NQ+1])
      );
    end else begin : g_pass
      for (genvar p = 0; p < (RIN % 4); p++) begin : g_p
        assign lvl_out[k][2*NQ+p] = lvl_in[k][4*NQ+p];
      end
    end
    for (genvar r = ROUT; r < DATA_LEN; r++) begin : g_out_tie
      assign lvl_out[k][r] = '0;
    end
  end

  if (NLEV == 1) begin : g_fin_s1
    assign red_sum   = s1_rows_q[0];
    assign red_carry = s1_rows_q[1];
  end else begin : g_fin_tree
    assign red_sum   = lvl_out[NLEV-1][0];
    assign red_carry = lvl_out[NLEV-1][1];
  end

  always_comb begin
    rdy3       = !s3_q.valid || out_ready;
    rdy2       = !s2_q.valid || rdy3;
    rdy1       = !s1_q.valid || rdy2;
    s1_d       = s1_q;
    s2_d       = s2_q;
    s3_d       = s3_q;
    s1_rows_d  = s1_rows_q;
    s2_sum_d   = s2_sum_q;
    s2_carry_d = s2_carry_q;
    res_d      = res_q;
    if (rdy1) begin
      s1_d.valid = in_valid;
      if (in_valid) begin
        s1_d.tag = in_tag;
        for (int r = 0; r < R1; r++) s1_rows_d[r] = lvl_out[0][r];
      end
    end
    if (rdy2) begin
      s2_d.valid = s1_q.valid;
      if (s1_q.valid) begin
        s2_d.tag   = s1_q.tag;
        s2_sum_d   = red_sum;
        s2_carry_d = red_carry;
      end
    end
    if (rdy3) begin
      s3_d.valid = s2_q.valid;
      if (s2_q.valid) begin
        s3_d.tag = s2_q.tag;
        res_d    = s2_sum_q + s2_carry_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= '0;
      for (int r = 0; r < R1; r++) s1_rows_q[r] <= '0;
      s2_sum_q   <= '0;
      s2_carry_q <= '0;
      res_q      <= '0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
      for (int r = 0; r < R1; r++) s1_rows_q[r] <= s1_rows_d[r];
      s2_sum_q   <= s2_sum_d;
      s2_carry_q <= s2_carry_d;
      res_q      <= res_d;
    end
  end

  assign in_ready   = rdy1;
  assign out_valid  = s3_q.valid;
  assign out_tag    = s3_q.tag;
  assign mul_result = res_q;

endmodule

// File: tb/tb_mul_4to2_tree_pipe.sv
// Bench for mul_4to2_tree_pipe at DATA_LEN 8 (directed + random) and 16 (random).
module tb_mul_4to2_tree_pipe;
  localparam int N  = 8;
  localparam int NW = 16;
  localparam int TW = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic            in_valid = 1'b0, is_signed = 1'b0, out_ready = 1'b1;
  logic            in_ready, out_valid;
  logic [N-1:0]    op1 = '0, op2 = '0;
  logic [TW-1:0]   in_tag = '0, out_tag;
  logic [2*N-1:0]  mul_result;

  logic            w_in_valid = 1'b0, w_is_signed = 1'b0, w_out_ready = 1'b1;
  logic            w_in_ready, w_out_valid;
  logic [NW-1:0]   w_op1 = '0, w_op2 = '0;
  logic [TW-1:0]   w_in_tag = '0, w_out_tag;
  logic [2*NW-1:0] w_mul_result;

  mul_4to2_tree_pipe #(.DATA_LEN(N), .TAG_W(TW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op1(op1), .op2(op2),
    .is_signed(is_signed), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
    .mul_result(mul_result), .out_tag(out_tag)
  );

  mul_4to2_tree_pipe #(.DATA_LEN(NW), .TAG_W(TW)) dut_w (
    .clk(clk), .rst_n(rst_n), .in_valid(w_in_valid), .in_ready(w_in_ready), .op1(w_op1), .op2(w_op2),
    .is_signed(w_is_signed), .in_tag(w_in_tag), .out_valid(w_out_valid), .out_ready(w_out_ready),
    .mul_result(w_mul_result), .out_tag(w_out_tag)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0, n_err = 0, n_acc = 0, n_out = 0, n_out_w = 0;
  logic [TW+2*N-1:0]  exp_q[$];
  logic [TW+2*NW-1:0] exp_w_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: sign-extend from n bits when signed, multiply as integers, keep 2n bits.
  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                          input logic s, input int n);
    longint x, y;
    x = longint'(a);
    y = longint'(b);
    if (s && a[n-1]) x = x - (longint'(1) << n);
    if (s && b[n-1]) y = y - (longint'(1) << n);
    return 64'(x * y) & ((64'd1 << (2*n)) - 64'd1);
  endfunction

  function automatic logic [31:0] pick(input int n);
    logic [31:0] v;
    v = $urandom;
    case ($urandom_range(0, 5))
      0: v = '0;
      1: v = '1;
      2: v = 32'd1 << (n - 1);
      3: v = (32'd1 << (n - 1)) - 32'd1;
      default: ;
    endcase
    return v & 32'((64'd1 << n) - 64'd1);
  endfunction

  logic              stall_p = 1'b0;
  logic [TW+2*N-1:0] held_p = '0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (stall_p) check("hold", 64'({out_valid, out_tag, mul_result}), 64'({1'b1, held_p}));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("spurious_out", 64'(1), 64'(0));
        else check("result", 64'({out_tag, mul_result}), 64'(exp_q.pop_front()));
        n_out++;
      end
      stall_p = out_valid && !out_ready;
      held_p  = {out_tag, mul_result};
    end else begin
      stall_p = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (rst_n && w_out_valid && w_out_ready) begin
      if (exp_w_q.size() == 0) check("spurious_out16", 64'(1), 64'(0));
      else check("result16", 64'({w_out_tag, w_mul_result}), 64'(exp_w_q.pop_front()));
      n_out_w++;
    end
  end

  // ---------------- drivers (called at posedge + 1) ----------------
  task automatic drive(input logic [N-1:0] a, input logic [N-1:0] b, input logic s,
                       input logic [TW-1:0] t, input logic [2*N-1:0] exp);
    int waits;
    waits = 0;
    op1 = a; op2 = b; is_signed = s; in_tag = t; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && waits < 200) begin
      @(negedge clk);
      waits++;
    end
    if (!in_ready) check("accept_timeout", 64'(0), 64'(1));
    else begin
      exp_q.push_back({t, exp});
      n_acc++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drive_rand();
    logic [31:0] a, b;
    logic [63:0] r;
    logic        s;
    logic [TW-1:0] t;
    a = pick(N);
    b = pick(N);
    s = 1'($urandom_range(0, 1));
    t = TW'($urandom);
    r = ref_mul(a, b, s, N);
    drive(a[N-1:0], b[N-1:0], s, t, r[2*N-1:0]);
  endtask

  task automatic drive_rand_w();
    logic [31:0] a, b;
    logic [63:0] r;
    logic        s;
    logic [TW-1:0] t;
    int waits;
    a = pick(NW);
    b = pick(NW);
    s = 1'($urandom_range(0, 1));
    t = TW'($urandom);
    r = ref_mul(a, b, s, NW);
    waits = 0;
    w_op1 = a[NW-1:0]; w_op2 = b[NW-1:0]; w_is_signed = s; w_in_tag = t; w_in_valid = 1'b1;
    @(negedge clk);
    while (!w_in_ready && waits < 200) begin
      @(negedge clk);
      waits++;
    end
    if (!w_in_ready) check("accept_timeout16", 64'(0), 64'(1));
    else exp_w_q.push_back({t, r[2*NW-1:0]});
    @(posedge clk); #1;
    w_in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() + exp_w_q.size()) != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    check("drain", 64'(exp_q.size() + exp_w_q.size()), 64'(0));
    @(posedge clk); #1;
  endtask

  // ---------------- main sequence ----------------
  int base, acc0, t0;
  logic done;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_in_ready", 64'(in_ready), 64'(1));
    check("rst_result", 64'(mul_result), 64'(0));
    check("rst_tag", 64'(out_tag), 64'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Latency and the unsigned corner.
    drive(8'hFF, 8'hFF, 1'b0, 4'd3, 16'hFE01);
    @(negedge clk); check("lat_c1", 64'(out_valid), 64'(0));
    @(negedge clk); check("lat_c2", 64'(out_valid), 64'(0));
    @(negedge clk); check("lat_c3", 64'(out_valid), 64'(1));
    check("u255_result", 64'(mul_result), 64'(16'hFE01));
    check("u255_tag", 64'(out_tag), 64'(3));
    @(posedge clk); #1;

    // Signed corners and mixed-mode beats, one accept per cycle.
    base = n_out;
    t0 = cyc;
    drive(8'h80, 8'h80, 1'b1, 4'd1, 16'h4000);
    drive(8'h80, 8'h7F, 1'b1, 4'd2, 16'hC080);
    drive(8'hFF, 8'h01, 1'b1, 4'd4, 16'hFFFF);
    drive(8'h80, 8'h02, 1'b0, 4'd5, 16'h0100);
    drive(8'h80, 8'h02, 1'b1, 4'd6, 16'hFF00);
    check("b2b_accept_cycles", 64'(cyc - t0), 64'(5));
    repeat (3) begin
      @(negedge clk);
      check("b2b_out_valid", 64'(out_valid), 64'(1));
    end
    @(posedge clk); #1;
    drain();
    check("b2b_count", 64'(n_out - base), 64'(5));

    // Output stalled for 5 cycles with 4 beats offered.
    out_ready = 1'b0;
    base = n_out;
    acc0 = n_acc;
    fork
      begin
        for (int i = 0; i < 4; i++) drive_rand();
      end
      begin
        repeat (5) @(negedge clk);
        check("stall_accepted", 64'(n_acc - acc0), 64'(3));
        check("stall_in_ready", 64'(in_ready), 64'(0));
        check("stall_out_valid", 64'(out_valid), 64'(1));
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    drain();
    check("stall_count", 64'(n_out - base), 64'(4));

    // One beat parked in S3; empty earlier stages must keep accepting.
    out_ready = 1'b0;
    base = n_out;
    drive_rand();
    repeat (3) @(negedge clk);
    check("bubble_out_valid", 64'(out_valid), 64'(1));
    check("bubble_rdy", 64'(in_ready), 64'(1));
    @(posedge clk); #1;
    t0 = cyc;
    drive_rand();
    drive_rand();
    check("bubble_no_wait", 64'(cyc - t0), 64'(2));
    @(negedge clk);
    check("bubble_full", 64'(in_ready), 64'(0));
    @(posedge clk); #1;
    out_ready = 1'b1;
    drain();
    check("bubble_count", 64'(n_out - base), 64'(3));

    // Reset with three beats in flight.
    drive_rand();
    drive_rand();
    drive_rand();
    #2;
    check("pre_rst_valid", 64'(out_valid), 64'(1));
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 64'(out_valid), 64'(0));
    check("async_rst_ready", 64'(in_ready), 64'(1));
    check("async_rst_result", 64'(mul_result), 64'(0));
    exp_q.delete();
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("post_rst_idle", 64'(out_valid), 64'(0));
    end
    @(posedge clk); #1;
    base = n_out;
    drive_rand();
    drain();
    check("post_rst_count", 64'(n_out - base), 64'(1));

    // Random beats with random gaps and random back-pressure, DATA_LEN 8.
    done = 1'b0;
    base = n_out;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
          end
          drive_rand();
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    drain();
    check("rand8_count", 64'(n_out - base), 64'(300));

    // Random beats, DATA_LEN 16.
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 200; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
          end
          drive_rand_w();
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          w_out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    w_out_ready = 1'b1;
    drain();
    check("rand16_count", 64'(n_out_w), 64'(200));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    n_err++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "watchdog expired");
  end

endmodule
